gcd_requester: RTL and testbench
================================

GCD_REQUESTER -- requirements
Module: gcd_requester

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter TIMEOUT, default 64: maximum number of cycles spent waiting for gcd_done; must be at least 2.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: upstream operand pair is valid.
REQ-006 Port in_ready, output, 1: block accepts an operand pair.
REQ-007 Port in_a, input, WIDTH: operand A.
REQ-008 Port in_b, input, WIDTH: operand B.
REQ-009 Port gcd_start, output, 1: start strobe to the GCD core.
REQ-010 Port gcd_data, output, WIDTH: shared operand load bus to the GCD core.
REQ-011 Port gcd_done, input, 1: GCD core completion flag.
REQ-012 Port gcd_result, input, WIDTH: GCD core result; valid while gcd_done is high.
REQ-013 Port out_valid, output, 1: result is valid.
REQ-014 Port out_ready, input, 1: downstream accepts the result.
REQ-015 Port out_result, output, WIDTH: GCD(A,B), or 0 on timeout.
REQ-016 Port out_timeout, output, 1: qualifies out_result; high when the core never completed.
REQ-017 Port op_count, output, 16: count of results delivered downstream; wraps from 0xFFFF to 0.

Function
REQ-018 The block SHALL implement a five-state FSM: IDLE, LOAD_A, LOAD_B, WAIT, OUT.
REQ-019 The FSM SHALL assert in_ready only in IDLE.
REQ-020 An operand pair SHALL be accepted on a clock edge where in_valid and in_ready are both high; at that edge in_a and in_b SHALL be captured into internal registers.
REQ-021 On acceptance with both operands nonzero, the FSM SHALL go to LOAD_A.
REQ-022 On acceptance with either operand zero, the FSM SHALL bypass the core:
- next state is OUT
- out_result = in_a | in_b (so GCD(0,0)=0)
- out_timeout = 0
- gcd_start is never asserted
REQ-023 LOAD_A SHALL last exactly one cycle: gcd_start=1, gcd_data=A; next state LOAD_B.
REQ-024 LOAD_B SHALL last exactly one cycle: gcd_start=0, gcd_data=B; next state WAIT; wait counter cleared to 0.
REQ-025 Outside LOAD_A and LOAD_B, gcd_start SHALL be 0 and gcd_data SHALL be 0.
REQ-026 In WAIT, the wait counter SHALL increment by 1 every cycle.
REQ-027 In WAIT, if gcd_done=1 at an edge, the block SHALL capture gcd_result into out_result, set out_timeout=0 and go to OUT.
REQ-028 In WAIT, if the counter equals TIMEOUT-1 and gcd_done=0, the block SHALL set out_result=0, out_timeout=1 and go to OUT.
REQ-029 If gcd_done and the timeout condition occur in the same cycle, gcd_done SHALL win.
REQ-030 gcd_done SHALL be ignored in every state except WAIT.
REQ-031 In OUT, out_valid=1, and out_result and out_timeout SHALL be held stable until out_valid and out_ready are both high at an edge.
REQ-032 At that OUT handshake edge, the FSM SHALL return to IDLE and op_count SHALL increment by 1.
REQ-033 Latency, with acceptance at edge T:
- gcd_start is high in cycle T+1
- B is on gcd_data in cycle T+2
- WAIT begins in cycle T+3
- out_valid rises in the cycle after the edge where gcd_done is sampled
- bypass: out_valid rises in cycle T+1
REQ-034 Back-to-back operation SHALL add no idle cycles beyond the single IDLE cycle between OUT and the next acceptance.
REQ-035 All outputs SHALL be registered or decoded directly from the state register; there SHALL be no combinational path from any input to any output.

Reset
REQ-036 While rst=1 at an edge, the block SHALL force:
- state to IDLE
- out_valid, out_timeout, gcd_start to 0
- gcd_data, out_result, op_count, wait counter and operand registers to 0
REQ-037 in_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-038 Reset asserted in any state, including mid-WAIT or OUT with a pending result, SHALL abandon the operation with no further gcd_start and no out_valid for it.

Verification
REQ-039 Simple pair: (in_a=48, in_b=18) with a behavioural GCD core -> one-cycle gcd_start with gcd_data=48, next cycle gcd_data=18, then out_result=6, out_timeout=0, op_count=1.
REQ-040 Zero bypass: (0, 35) -> out_valid one cycle after acceptance, out_result=35, gcd_start never high; (0, 0) -> out_result=0.
REQ-041 Timeout: core holds gcd_done=0, TIMEOUT=64 -> out_valid 64 cycles after WAIT entry, out_timeout=1, out_result=0; gcd_done and timeout in the same cycle -> out_timeout=0.
REQ-042 Backpressure: out_ready low for 10 cycles after (270, 192) -> out_valid, out_result=6 and in_ready=0 all held; op_count increments only on the handshake.
REQ-043 Reset during WAIT and during OUT -> next cycle IDLE, all outputs 0 except in_ready=1; a following (17, 5) completes with out_result=1.
REQ-044 Four back-to-back pairs with in_valid held high and op_count preloaded near 0xFFFF -> correct results in order, and op_count wraps to 0.

Source files
------------

// File: rtl/gcd_requester.sv
// rtl/gcd_requester.sv - operand sequencer and result holder for an external GCD core
module gcd_requester #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_timeout,
    output logic [15:0]      op_count
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        WAIT   = 3'd3,
        OUT    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    wait_cnt, wait_cnt_d;
    logic [WIDTH-1:0] result_d;
    logic             timeout_d;
    logic [15:0]      op_count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            wait_cnt    <= '0;
            out_result  <= '0;
            out_timeout <= 1'b0;
            op_count    <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            wait_cnt    <= wait_cnt_d;
            out_result  <= result_d;
            out_timeout <= timeout_d;
            op_count    <= op_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        wait_cnt_d = wait_cnt;
        result_d   = out_result;
        timeout_d  = out_timeout;
        op_count_d = op_count;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d = in_a;
                    b_d = in_b;
                    if (in_a != '0 && in_b != '0) begin
                        state_d = LOAD_A;
                    end else begin
                        // GCD(x,0) = x, so a zero operand never needs the core
                        state_d   = OUT;
                        result_d  = in_a | in_b;
                        timeout_d = 1'b0;
                    end
                end
            end
            LOAD_A: state_d = LOAD_B;
            LOAD_B: begin
                state_d    = WAIT;
                wait_cnt_d = '0;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt + 1'b1;
                // completion is checked first so it beats a simultaneous timeout
                if (gcd_done) begin
                    state_d   = OUT;
                    result_d  = gcd_result;
                    timeout_d = 1'b0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_d   = OUT;
                    result_d  = '0;
                    timeout_d = 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d    = IDLE;
                    op_count_d = op_count + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign gcd_start = (state_q == LOAD_A);
    assign out_valid = (state_q == OUT);

    always_comb begin
        gcd_data = '0;
        if (state_q == LOAD_A) begin
            gcd_data = a_q;
        end else if (state_q == LOAD_B) begin
            gcd_data = b_q;
        end
    end
endmodule

// File: tb/tb_gcd_requester.sv
// tb/tb_gcd_requester.sv - randomized and directed checks of gcd_requester against a timeline model
module tb_gcd_requester;
    localparam int W = 16;
    localparam int TO = 64;
    localparam logic [15:0] PRELOAD = 16'hFFFD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_ready;
    logic          gcd_start;
    logic [W-1:0]  gcd_data;
    logic          gcd_done = 1'b0;
    logic [W-1:0]  gcd_result = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_result;
    logic          out_timeout;
    logic [15:0]   op_count;

    gcd_requester #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .gcd_start(gcd_start), .gcd_data(gcd_data),
        .gcd_done(gcd_done), .gcd_result(gcd_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_timeout(out_timeout), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rdy_mode = 1;
    int preload_seq = 0;
    int preload_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int ref_gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [W-1:0] bin_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] u, v, t;
        int k;
        u = x; v = y; k = 0;
        if (u == 0) return v;
        if (v == 0) return u;
        while (u[0] == 1'b0 && v[0] == 1'b0) begin u = u >> 1; v = v >> 1; k++; end
        while (u[0] == 1'b0) u = u >> 1;
        while (v != 0) begin
            while (v[0] == 1'b0) v = v >> 1;
            if (u > v) begin t = u; u = v; v = t; end
            v = v - u;
        end
        return u << k;
    endfunction

    // Transaction timeline model: acceptance cycle, bypass flag, pending result, delivered count
    bit           started = 0, m_active = 0, m_bypass = 0, m_have_out = 0, m_fresh = 1, m_tmo = 0;
    int           m_acc = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic [15:0]  m_count = '0;

    always @(posedge clk) begin
        if (preload_seq != preload_seen) begin
            m_count = PRELOAD;
            preload_seen = preload_seq;
        end
        if (rst) begin
            started = 1; m_active = 0; m_have_out = 0; m_fresh = 1;
            m_count = '0; m_res = '0; m_tmo = 0;
        end else if (!m_active) begin
            if (in_valid) begin
                m_active = 1; m_fresh = 0; m_acc = cyc; m_a = in_a; m_b = in_b;
                m_bypass = (in_a == 0 || in_b == 0);
                if (m_bypass) begin
                    m_have_out = 1; m_res = in_a | in_b; m_tmo = 0;
                end else begin
                    m_have_out = 0;
                end
            end
        end else if (m_have_out) begin
            if (out_ready) begin
                m_active = 0; m_have_out = 0; m_count = m_count + 16'd1;
            end
        end else if (!m_bypass && cyc >= m_acc + 3) begin
            if (gcd_done) begin
                m_have_out = 1; m_res = W'(ref_gcd(int'(m_a), int'(m_b))); m_tmo = 0;
            end else if (cyc == m_acc + 3 + TO - 1) begin
                m_have_out = 1; m_res = '0; m_tmo = 1;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        logic [W-1:0] exp_data;
        if (started) begin
            exp_data = '0;
            if (m_active && !m_bypass && cyc == m_acc + 1) exp_data = m_a;
            if (m_active && !m_bypass && cyc == m_acc + 2) exp_data = m_b;
            chk("in_ready", 32'(in_ready), 32'(!m_active));
            chk("out_valid", 32'(out_valid), 32'(m_active && m_have_out));
            chk("gcd_start", 32'(gcd_start), 32'(m_active && !m_bypass && cyc == m_acc + 1));
            chk("gcd_data", 32'(gcd_data), 32'(exp_data));
            chk("op_count", 32'(op_count), 32'(m_count));
            if (m_fresh || (m_active && m_have_out)) begin
                chk("out_result", 32'(out_result), 32'(m_res));
                chk("out_timeout", 32'(out_timeout), 32'(m_tmo));
            end
        end
    end

    always @(negedge clk) begin
        case (rdy_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Behavioural GCD core; each non-bypass operation carries its own latency / hang setting
    typedef struct { int delay; bit hang; } job_t;
    typedef enum { C_IDLE, C_GOTA, C_ARM, C_HUNG } core_t;
    job_t         jobs[$];
    job_t         cur_job;
    core_t        core_st = C_IDLE;
    int           core_cd = 0;
    logic [W-1:0] core_a = '0, core_res = '0;

    always @(negedge clk) begin
        gcd_done = 1'b0;
        gcd_result = '0;
        if (rst) begin
            core_st = C_IDLE;
        end else begin
            case (core_st)
                C_ARM: begin
                    if (core_cd == 0) begin
                        gcd_done = 1'b1; gcd_result = core_res; core_st = C_IDLE;
                    end else begin
                        core_cd--;
                    end
                end
                C_GOTA: begin
                    core_res = bin_gcd(core_a, gcd_data);
                    core_cd = cur_job.delay;
                    core_st = cur_job.hang ? C_HUNG : C_ARM;
                end
                C_HUNG: if (out_valid) core_st = C_IDLE;
                default: ;
            endcase
            if (gcd_start) begin
                core_a = gcd_data;
                core_st = C_GOTA;
                if (jobs.size() > 0) cur_job = jobs.pop_front();
                else begin cur_job.delay = 0; cur_job.hang = 0; end
            end
            // stray completions while no operation is outstanding must be ignored
            if (core_st == C_IDLE && !gcd_done && $urandom_range(0, 3) == 0) begin
                gcd_done = 1'b1;
                gcd_result = W'($urandom);
            end
        end
    end

    task automatic send_pair(input int a, input int b, input int dly, input bit hang);
        int k;
        job_t j;
        in_a = W'(a); in_b = W'(b); in_valid = 1'b1;
        if (a != 0 && b != 0) begin
            j.delay = dly; j.hang = hang; jobs.push_back(j);
        end
        k = 0;
        while (in_ready !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        chk("accept_wait", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        chk("valid_wait", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        chk("idle_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_gcd_start"}, 32'(gcd_start), 32'd0);
        chk({tag, "_gcd_data"}, 32'(gcd_data), 32'd0);
        chk({tag, "_out_result"}, 32'(out_result), 32'd0);
        chk({tag, "_out_timeout"}, 32'(out_timeout), 32'd0);
        chk({tag, "_op_count"}, 32'(op_count), 32'd0);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        chk("pin_gcd_48_18", 32'(ref_gcd(48, 18)), 32'd6);
        chk("pin_gcd_270_192", 32'(ref_gcd(270, 192)), 32'd6);
        chk("pin_gcd_17_5", 32'(ref_gcd(17, 5)), 32'd1);
        chk("pin_bin_40_24", 32'(bin_gcd(16'd40, 16'd24)), 32'd8);

        // simple pair
        send_pair(48, 18, 2, 0);
        in_valid = 1'b0;
        chk("simple_start", 32'(gcd_start), 32'd1);
        chk("simple_data_a", 32'(gcd_data), 32'd48);
        @(negedge clk);
        chk("simple_start_low", 32'(gcd_start), 32'd0);
        chk("simple_data_b", 32'(gcd_data), 32'd18);
        wait_valid();
        chk("simple_result", 32'(out_result), 32'd6);
        chk("simple_timeout", 32'(out_timeout), 32'd0);
        wait_idle();
        chk("simple_count", 32'(op_count), 32'd1);

        // zero bypass: result visible in the cycle after acceptance
        send_pair(0, 35, 0, 0);
        in_valid = 1'b0;
        chk("bypass_valid", 32'(out_valid), 32'd1);
        chk("bypass_result", 32'(out_result), 32'd35);
        chk("bypass_start", 32'(gcd_start), 32'd0);
        wait_idle();
        send_pair(0, 0, 0, 0);
        in_valid = 1'b0;
        chk("zero_zero_result", 32'(out_result), 32'd0);
        wait_idle();

        // timeout: accepted at edge T, WAIT starts T+3 and lasts TO cycles -> out_valid 66 cycles after T+1
        send_pair(40, 24, 0, 1);
        in_valid = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        chk("timeout_latency", 32'(k), 32'd66);
        chk("timeout_flag", 32'(out_timeout), 32'd1);
        chk("timeout_result", 32'(out_result), 32'd0);
        wait_idle();

        // done in the last WAIT cycle beats the timeout
        send_pair(40, 24, TO - 1, 0);
        in_valid = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        chk("tie_latency", 32'(k), 32'd66);
        chk("tie_flag", 32'(out_timeout), 32'd0);
        chk("tie_result", 32'(out_result), 32'd8);
        wait_idle();

        // done one cycle too late arrives in OUT and is ignored
        send_pair(40, 24, TO, 0);
        in_valid = 1'b0;
        wait_valid();
        chk("late_flag", 32'(out_timeout), 32'd1);
        chk("late_result", 32'(out_result), 32'd0);
        wait_idle();

        // backpressure
        rdy_mode = 0;
        @(negedge clk);
        send_pair(270, 192, 3, 0);
        in_valid = 1'b0;
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_result", 32'(out_result), 32'd6);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_count", 32'(op_count), 32'd6);
            @(negedge clk);
        end
        rdy_mode = 1;
        wait_idle();
        chk("bp_count_after", 32'(op_count), 32'd7);

        // reset during WAIT
        send_pair(100, 75, 0, 1);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("rst_wait");
        rst = 1'b0;

        // reset during OUT with a pending result
        rdy_mode = 0;
        @(negedge clk);
        send_pair(9, 6, 2, 0);
        in_valid = 1'b0;
        wait_valid();
        chk("pre_reset_result", 32'(out_result), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("rst_out");
        rst = 1'b0;
        rdy_mode = 1;
        @(negedge clk);
        send_pair(17, 5, 1, 0);
        in_valid = 1'b0;
        wait_valid();
        chk("post_reset_result", 32'(out_result), 32'd1);
        wait_idle();

        // back-to-back with op_count wrapping
        @(negedge clk);
        #2;
        dut.op_count = PRELOAD;
        preload_seq = preload_seq + 1;
        @(negedge clk);
        chk("preload_count", 32'(op_count), 32'(PRELOAD));
        send_pair(12, 8, 1, 0);
        send_pair(0, 7, 0, 0);
        send_pair(21, 14, 0, 0);
        send_pair(81, 27, 4, 0);
        in_valid = 1'b0;
        wait_idle();
        chk("wrap_count", 32'(op_count), 32'd1);

        // randomized traffic
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            int m, a, b, sel, dly;
            m = $urandom_range(1, 40);
            a = $urandom_range(1, 300) * m;
            b = $urandom_range(1, 300) * m;
            if ($urandom_range(0, 7) == 0) a = 0;
            if ($urandom_range(0, 7) == 0) b = 0;
            sel = $urandom_range(0, 9);
            dly = (sel == 1) ? TO - 1 : $urandom_range(0, 12);
            send_pair(a, b, dly, sel == 0);
            if ($urandom_range(0, 1) == 1) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        rdy_mode = 1;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
